// File: rtl/kp_pkg.sv
// Shared definitions for the keypad event queue: event word layout,
// timestamp width and the event word packing helper.
package kp_pkg;

  localparam int EV_W        = 16;
  localparam int EV_TYPE_BIT = 15;
  localparam int EV_TS_MSB   = 14;
  localparam int EV_TS_LSB   = 8;
  localparam int EV_KEY_MSB  = 7;
  localparam int TS_W        = 7;
  localparam int KEY_W       = 8;

  localparam logic EV_PRESS   = 1'b1;
  localparam logic EV_RELEASE = 1'b0;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [TS_W-1:0]  ts_t;
  typedef logic [EV_W-1:0]  ev_word_t;

  // Assemble one event word from its type, timestamp and key code.
  function automatic ev_word_t pack_event(input logic typ, input ts_t ts, input key_t key);
    ev_word_t ev;
    ev                        = '0;
    ev[EV_TYPE_BIT]           = typ;
    ev[EV_TS_MSB:EV_TS_LSB]   = ts;
    ev[EV_KEY_MSB:0]          = key;
    return ev;
  endfunction

endpackage

// File: rtl/kp_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO. A pop on an empty FIFO
// is ignored; a push while full only succeeds when a pop frees a slot in
// the same cycle. The read port shows zero while empty.
module kp_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Decide which requests succeed and advance pointers/occupancy.
  always_comb begin
    do_pop   = rd_en & (count_q != '0);
    do_push  = wr_en & ((count_q != CNT_FULL) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Head of queue falls through; zero is presented while empty.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_FULL);
    count   = count_q;
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Keypad event queue: turns the scanner strobe and key-state vector into
// timestamped press/release words and buffers them for a processor.
module keypad_event_queue
  import kp_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 100000
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic [15:0]                iKEYST,
  input  logic [7:0]                 iKEYNUM,
  input  logic                       iKEY_IRQ,
  input  logic                       iRD_EN,
  input  logic                       iIRQ_EN,
  input  logic                       iCLR_OVF,
  output logic [15:0]                oDATA,
  output logic                       oEMPTY,
  output logic [$clog2(DEPTH):0]     oCOUNT,
  output logic                       oOVF,
  output logic                       oIRQ
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam ts_t           TS_ONE     = TS_W'(1);

  logic          irq_q, irq_d;
  logic          nz_q, nz_d;
  key_t          last_key_q, last_key_d;
  logic [PW-1:0] presc_q, presc_d;
  ts_t           tick_q, tick_d;
  logic          ovf_q, ovf_d;

  logic          press_det;
  logic          rel_det;
  logic          push;
  ev_word_t      ev_word;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;

  // Edge detection, event word selection and last-key tracking.
  always_comb begin
    press_det  = iKEY_IRQ & ~irq_q;
    rel_det    = ~(|iKEYST) & nz_q;
    push       = press_det | rel_det;
    // A press and a release in the same cycle: only the press is kept.
    ev_word    = press_det ? pack_event(EV_PRESS, tick_q, iKEYNUM)
                           : pack_event(EV_RELEASE, tick_q, last_key_q);
    irq_d      = iKEY_IRQ;
    nz_d       = |iKEYST;
    last_key_d = press_det ? iKEYNUM : last_key_q;
  end

  // Prescaler and 7-bit tick counter; the tick wraps naturally at 127.
  always_comb begin
    presc_d = presc_q + PRESC_ONE;
    tick_d  = tick_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_d  = tick_q + TS_ONE;
    end
  end

  // Sticky overflow: a drop sets it and beats a simultaneous clear.
  always_comb begin
    drop  = push & fifo_full & ~iRD_EN;
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (iCLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  // Control registers, all cleared by synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      irq_q      <= 1'b0;
      nz_q       <= 1'b0;
      last_key_q <= '0;
      presc_q    <= '0;
      tick_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      irq_q      <= irq_d;
      nz_q       <= nz_d;
      last_key_q <= last_key_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      ovf_q      <= ovf_d;
    end
  end

  kp_sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (iCLK),
    .rst     (iRST),
    .wr_en   (push),
    .wr_data (ev_word),
    .rd_en   (iRD_EN),
    .rd_data (oDATA),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (oCOUNT)
  );

  // Status outputs; the interrupt follows the FIFO state with no delay.
  always_comb begin
    oEMPTY = fifo_empty;
    oOVF   = ovf_q;
    oIRQ   = iIRQ_EN & ~fifo_empty;
  end

endmodule
